alu32_sched: RTL and testbench
==============================

// Module: alu32_sched
// PURPOSE
//  Shares one combinational 32-bit ALU (op[2:0], c/n/z/v flags) between two requesters.
//  Round-robin arbitration, operand capture, and ALU_LAT-cycle execution wait.
//  Returns result+flags on a single tagged response channel with valid/ready backpressure.
//  Keeps a sticky status register holding the flags of the last completed op.
// PARAMETERS
//  ALU_LAT   1   cycles from alu_op/a/b stable to alu_result/flags sampled; legal 1..15
// PORTS
//  clk          in   1   system clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  req0_valid   in   1   requester 0 has an op pending
//  req0_ready   out  1   requester 0 op accepted this cycle
//  req0_op      in   3   ALU opcode
//  req0_a       in   32  operand A
//  req0_b       in   32  operand B
//  req1_*       -    -   same set as req0_* for requester 1
//  alu_op       out  3   opcode driven to ALU
//  alu_a        out  32  operand A driven to ALU
//  alu_b        out  32  operand B driven to ALU
//  alu_result   in   32  ALU result
//  alu_c/n/z/v  in   1   ALU flags
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   consumer accepts response
//  rsp_id       out  1   requester that issued the op
//  rsp_result   out  32  captured result
//  rsp_flags    out  4   captured {n,z,c,v}
//  status_flags out  4   {n,z,c,v} of last completed (handshaken) op
//  busy         out  1   1 when state != IDLE
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, all outputs 0, alu_* regs 0, last_grant=1 (req0 wins first tie).
//  Opcodes: 000 ~A, 001 ~B, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 ADD, 111 SUB (A-B = A+~B+1).
//  Flags come from the ALU unchanged: c,v are 0 for ops 000..101; c = carry-out for ADD/SUB; z = (result==0).
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: if exactly one reqN_valid, grant N. If both are valid, grant !last_grant.
//         reqN_ready=1 (combinational) in that cycle only. Capture op/a/b into alu_* regs.
//         Load cnt=ALU_LAT-1 and go EXEC. With no valid request, stay in IDLE.
//   EXEC: alu_* held stable. While cnt!=0, decrement cnt. At cnt==0, capture alu_result and flags
//         into rsp_* and go RESP.
//   RESP: rsp_valid=1, rsp_* stable. On rsp_valid&rsp_ready: update status_flags,
//         set last_grant=rsp_id, go IDLE.
//  Latency: accept at cycle T; rsp_valid first high at T+1+ALU_LAT. Min issue interval ALU_LAT+2.
//  req*_ready is never high outside IDLE. A request arriving during RESP, even with a
//   simultaneous rsp_ready, is accepted no earlier than the following IDLE cycle.
//  Requesters must hold op/a/b stable while valid and not ready. A request that drops before grant is ignored.
//  Sustained contention alternates grants 0,1,0,1...; neither requester starves.
//  Backpressure: rsp_ready low holds RESP indefinitely with outputs unchanged; busy stays 1.
//  Reset mid-op: in-flight op is discarded; no rsp_valid after release; status_flags cleared.
//  alu_* keep the last op's values in IDLE; no reset or clear between ops.
// STRUCTURE
//  alu32_defs.vh: opcode localparams (OP_NOTA..OP_SUB), state encodings (S_IDLE/S_EXEC/S_RESP),
//   flag bit indices (F_N=3, F_Z=2, F_C=1, F_V=0).
//  Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], last_grant -> grant[1:0], combinational).
//  Counter width fixed at 4 bits.
// TESTING (ALU_LAT=1, real alu32 as DUT-side ALU)
//  1 Reset: reset_n=0 with random inputs -> rsp_valid=0, busy=0, req*_ready=0, status_flags=0.
//  2 req0 ADD 0x7FFFFFFF+0x00000001 at T -> req0_ready@T, rsp_valid@T+2, id=0,
//    result=0x80000000, flags=4'b1001.
//  3 req1 SUB 5-5 -> result=0, flags=4'b0110 (z=1, c=1, v=0); status_flags=0110 after handshake.
//  4 Both valid every cycle, rsp_ready=1, 6 ops -> grant order 0,1,0,1,0,1; no back-to-back same id.
//  5 rsp_ready=0 for 5 cycles during RESP with req0_valid=1 -> rsp_* stable, req0_ready=0, busy=1.
//    Accept occurs 1 cycle after the handshake.
//  6 reset_n pulsed low in EXEC -> no rsp_valid after release; next op completes normally.
//  7 ALU_LAT=3, req0 AND 0xF0F0F0F0&0x0FF00FF0 -> rsp_valid@T+4, result=0x00F000F0, flags=4'b0000.

Source files
------------

// File: rtl/alu32_sched_pkg.sv
// alu32_sched_pkg: opcodes, FSM states, flag bit positions and counter width for the shared-ALU scheduler.
package alu32_sched_pkg;

    localparam logic [2:0] OP_NOTA = 3'd0;
    localparam logic [2:0] OP_NOTB = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_SUB  = 3'd7;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic c, input logic v);
        logic [3:0] f;
        f      = '0;
        f[F_N] = n;
        f[F_Z] = z;
        f[F_C] = c;
        f[F_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu32_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb grant = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;

endmodule

// File: rtl/alu32_sched.sv
// alu32_sched: shares one external combinational 32-bit ALU between two requesters
// with round-robin grant, ALU_LAT-cycle wait and a valid/ready tagged response.
module alu32_sched
    import alu32_sched_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_c,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  status_flags,
    output logic        busy
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic [1:0]       grant;
    logic             accept, done, hs;

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        accept = (state == S_IDLE) && (|grant);
        done   = (state == S_EXEC) && (cnt == '0);
        hs     = (state == S_RESP) && rsp_ready;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;

    always_comb state_nx = accept ? S_EXEC : done ? S_RESP : hs ? S_IDLE : state;

    // Ready is gated by reset so a held-low reset never shows an accept.
    always_comb begin
        req0_ready = reset_n && (state == S_IDLE) && grant[0];
        req1_ready = reset_n && (state == S_IDLE) && grant[1];
        rsp_valid  = (state == S_RESP);
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            last_grant   <= 1'b1;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            status_flags <= '0;
        end else begin
            if (accept) begin
                alu_op <= grant[1] ? req1_op : req0_op;
                alu_a  <= grant[1] ? req1_a  : req0_a;
                alu_b  <= grant[1] ? req1_b  : req0_b;
                rsp_id <= grant[1];
                cnt    <= CNT_W'(ALU_LAT - 1);
            end
            if (state == S_EXEC && cnt != '0) cnt <= cnt - 1'b1;
            if (done) begin
                rsp_result <= alu_result;
                rsp_flags  <= pack_flags(alu_n, alu_z, alu_c, alu_v);
            end
            if (hs) begin
                status_flags <= rsp_flags;
                last_grant   <= rsp_id;
            end
        end
    end

endmodule

// File: tb/tb_alu32_sched.sv
// tb_alu32_sched: directed checks of alu32_sched at ALU_LAT=1 and ALU_LAT=3 with a behavioural ALU.
module tb_alu32_sched;
    import alu32_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result, rsp_result;
    logic        alu_c, alu_n, alu_z, alu_v;
    logic [3:0]  rsp_flags, status_flags;

    logic        d3_req0_ready, d3_req1_ready, d3_rsp_valid, d3_rsp_id, d3_busy;
    logic [2:0]  d3_alu_op;
    logic [31:0] d3_alu_a, d3_alu_b, d3_alu_result, d3_rsp_result;
    logic        d3_alu_c, d3_alu_n, d3_alu_z, d3_alu_v;
    logic [3:0]  d3_rsp_flags, d3_status_flags;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    function automatic logic [35:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_NOTA: r = ~a;
            OP_NOTB: r = ~b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            default: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
        endcase
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    assign {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_f(alu_op, alu_a, alu_b);
    assign {d3_alu_n, d3_alu_z, d3_alu_c, d3_alu_v, d3_alu_result} = alu_f(d3_alu_op, d3_alu_a, d3_alu_b);

    alu32_sched #(.ALU_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .status_flags(status_flags), .busy(busy)
    );

    alu32_sched #(.ALU_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(d3_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(d3_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(d3_alu_op), .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_result(d3_alu_result),
        .alu_c(d3_alu_c), .alu_n(d3_alu_n), .alu_z(d3_alu_z), .alu_v(d3_alu_v),
        .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d3_rsp_id), .rsp_result(d3_rsp_result),
        .rsp_flags(d3_rsp_flags), .status_flags(d3_status_flags), .busy(d3_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got, cyc;
        // Reset with random request inputs
        reset_n    = 1'b0;
        rsp_ready  = 1'($urandom);
        req0_valid = 1'($urandom);
        req1_valid = 1'($urandom);
        req0_op    = 3'($urandom);
        req1_op    = 3'($urandom);
        req0_a     = $urandom;
        req0_b     = $urandom;
        req1_a     = $urandom;
        req1_b     = $urandom;
        #3;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_status", status_flags, 0);
        tick();
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        reset_n    = 1'b1;
        tick();

        // req0 ADD overflow
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001;
        #1;
        chk("t2_req0_ready", req0_ready, 1);
        chk("t2_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("t2_exec_valid", rsp_valid, 0);
        chk("t2_exec_busy", busy, 1);
        tick();
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_id", rsp_id, 0);
        chk("t2_result", rsp_result, 32'h8000_0000);
        chk("t2_flags", rsp_flags, 4'b1001);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t2_status", status_flags, 4'b1001);
        chk("t2_idle_valid", rsp_valid, 0);

        // req1 SUB to zero
        req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'd5; req1_b = 32'd5;
        #1;
        chk("t3_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_id", rsp_id, 1);
        chk("t3_result", rsp_result, 32'd0);
        chk("t3_flags", rsp_flags, 4'b0110);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t3_status", status_flags, 4'b0110);

        // Sustained contention alternates grants
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h10; req0_b = 32'h1;
        req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'd3;  req1_b = 32'd1;
        rsp_ready  = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 60) begin
            tick();
            cyc++;
            if (rsp_valid) begin
                chk("t4_id", rsp_id, 32'(got % 2));
                chk("t4_result", rsp_result, (got % 2) ? 32'd2 : 32'h11);
                got++;
                if (got == 6) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        chk("t4_count", got, 6);
        tick();
        rsp_ready = 1'b0;
        chk("t4_status", status_flags, 4'b0010);

        // Backpressure in RESP with req0 pending
        req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'h10; req0_b = 32'h20;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_rsp_valid", rsp_valid, 1);
            chk("t5_result", rsp_result, 32'hFFFF_FFF0);
            chk("t5_flags", rsp_flags, 4'b1000);
            chk("t5_req0_ready", req0_ready, 0);
            chk("t5_busy", busy, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t5_hs_req0_ready", req0_ready, 0);
        tick();
        rsp_ready = 1'b0;
        chk("t5_accept_next", req0_ready, 1);
        chk("t5_idle_valid", rsp_valid, 0);
        chk("t5_status", status_flags, 4'b1000);
        tick();
        req0_valid = 1'b0;
        chk("t6_in_exec", busy, 1);

        // Reset pulse mid-EXEC discards the op
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", rsp_valid, 0);
        chk("t6_rst_status", status_flags, 0);
        tick();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1;
        #1;
        chk("t6_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rsp_id", rsp_id, 1);
        chk("t6_result", rsp_result, 32'd0);
        chk("t6_flags", rsp_flags, 4'b0110);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t6_status", status_flags, 4'b0110);

        // ALU_LAT=3 instance
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 32'hF0F0_F0F0; req0_b = 32'h0FF0_0FF0;
        #1;
        chk("t7_req0_ready", d3_req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        chk("t7_v_t1", d3_rsp_valid, 0);
        chk("t7_alu_a", d3_alu_a, 32'hF0F0_F0F0);
        tick();
        chk("t7_v_t2", d3_rsp_valid, 0);
        tick();
        chk("t7_v_t3", d3_rsp_valid, 0);
        chk("t7_alu_b", d3_alu_b, 32'h0FF0_0FF0);
        tick();
        chk("t7_v_t4", d3_rsp_valid, 1);
        chk("t7_result", d3_rsp_result, 32'h00F0_00F0);
        chk("t7_flags", d3_rsp_flags, 4'b0000);
        chk("t7_id", d3_rsp_id, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
